// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic units.
// Holds the FSM encoding and default operand width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Used by the bit-serial adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell.
// Registered sum, carry-out and signed overflow with start/done.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic             carry_msb;
    logic [CW-1:0]    cnt;

    logic fa_s;
    logic fa_cout;
    logic last_bit;
    logic load;
    logic step;
    logic finish;
    logic busy_next;

    full_adder u_fa (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load      = (state == IDLE) && start;
        step      = (state == RUN);
        finish    = (state == DONE);
        busy_next = load || (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            cnt       <= '0;
        end else if (load) begin
            a_sr      <= A;
            b_sr      <= B;
            sum_sr    <= '0;
            carry     <= Cin;
            carry_msb <= 1'b0;
            cnt       <= '0;
        end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
            carry  <= fa_cout;
            // carry entering the MSB is needed for signed overflow
            if (last_bit) begin
                carry_msb <= carry;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            S    <= '0;
            Cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= finish;
            if (finish) begin
                S    <= sum_sr;
                Cout <= carry;
                ovf  <= carry_msb ^ carry;
            end
        end
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder with a start/done handshake. It adds two operands plus a carry-in one bit per clock, LSB first, using a single full-adder cell. It is the additive counterpart of the team's full-subtractor arithmetic path and is used where area matters more than latency. It presents a registered sum, carry-out and signed-overflow flag to the surrounding datapath.

## Interface

**Parameters**
- WIDTH, default 8: operand and sum width in bits; legal range is 2 or more.

**Ports**
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request an addition; sampled only in IDLE.
- A, input, WIDTH: first operand; captured on an accepted start.
- B, input, WIDTH: second operand; captured on an accepted start.
- Cin, input, 1: carry-in; captured on an accepted start.
- busy, input-side status, output, 1: high in RUN and DONE.
- done, output, 1: one-cycle pulse; S, Cout and ovf are valid from this cycle on.
- S, output, WIDTH: sum, A+B+Cin mod 2^WIDTH.
- Cout, output, 1: carry out of the MSB.
- ovf, output, 1: two's-complement overflow, equal to carry into the MSB XOR Cout.

## Operation

**States: IDLE, RUN, DONE.**

- **IDLE**
  - start=1: load the A and B shift registers, set carry to Cin, set the bit counter to 0, go to RUN.
  - start=0: stay in IDLE.
- **RUN**, once per cycle:
  - Full-add the operand LSBs with carry.
  - Shift the sum bit into the MSB of the sum shift register.
  - Shift both operands right by one.
  - Update carry to the adder's carry-out.
  - Increment the counter.
  - Before the last bit, latch the carry going into the MSB.
  - When the counter reaches WIDTH-1 and that bit is processed, go to DONE.
- **DONE**
  - Copy the sum shift register to S, carry to Cout, and the computed overflow to ovf.
  - Assert done for exactly this cycle.
  - Return to IDLE.
- **Result holding**
  - S, Cout and ovf hold their values until the next DONE.
  - They do not change during RUN. Internal shift registers are separate from the output registers.
- **start outside IDLE**
  - start is ignored in RUN and DONE.
  - A held-high start is accepted again on the first IDLE cycle after DONE.
- **Operand capture**
  - A, B and Cin are don't-care except on an accepted start.
  - Changes to them during RUN do not affect the result.
- **Arithmetic**
  - Internal carry is 1 bit.
  - The counter is ceil(log2(WIDTH)) bits and does not wrap before the DONE transition.

## Timing

- **Reset values (rst=1 on an edge):**
  - State is IDLE.
  - busy=0, done=0, S=0, Cout=0, ovf=0.
  - Shift registers, carry and counter are cleared.
- **Reset precedence:** rst overrides everything, including start in the same cycle and an operation in RUN.
- **Reset mid-operation:** the result is discarded, done never pulses, and outputs read 0 on the cycle after reset.
- **Latency:**
  - start accepted at edge 0 gives RUN on edges 1..WIDTH.
  - done is high in the cycle after edge WIDTH+1.
  - Total is WIDTH+2 edges from the start edge to the done-visible edge.
  - The earliest restart is accepted at the edge following the done cycle.
  - Throughput is one addition per WIDTH+2 cycles.
- **Output timing:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **busy** rises in the cycle after an accepted start and falls in the cycle after done.

## Structure

- **Shared package serial_arith_pkg:**
  - State encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default WIDTH constant.
  - The same package also serves a future bit-serial subtractor.
- **Sub-module full_adder:**
  - Combinational; inputs A, B, Cin; outputs S, Cout.
  - S = A^B^Cin; Cout = (A&B)|(A&Cin)|(B&Cin).
  - Instantiated once, on the operand LSBs.
- **Top level:** the FSM, counter, three shift registers, carry flop, MSB-carry flop and output registers.

## Test plan

All cases use WIDTH=8.

1. A=8'h35, B=8'h4A, Cin=0, start pulse -> done 10 cycles after start; S=8'h7F, Cout=0, ovf=0; busy high for exactly 10 cycles.
2. A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1, ovf=0. Then A=8'h7F, B=8'h01 -> S=8'h80, Cout=0, ovf=1.
3. A=8'h80, B=8'h80, Cin=1 -> S=8'h01, Cout=1, ovf=1. Change A/B every cycle during RUN -> result unchanged.
4. Pulse start again at cycles 3 and 9 of a run (A=8'h10, B=8'h20) -> ignored; a single done with S=8'h30; no second operation starts.
5. Assert rst for one cycle at RUN cycle 4 of A=8'hAA, B=8'h55 -> next cycle busy=0, S=0, Cout=0, ovf=0; no done pulse. A fresh start then completes normally with S=8'hFF.
6. Hold start high continuously with A=8'h01, B=8'h01 -> back-to-back operations each WIDTH+2 cycles apart; every done pulse is one cycle wide with S=8'h02.
